// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for the multicycle RV32I core
module multicycle_control_fsm #(
    parameter int COUNT_WIDTH     = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                   clockCPU,
    input  logic                   reset,
    input  logic [31:0]            iInst,
    output logic                   oRegWrite,
    output logic                   oALUSrcA,
    output logic [1:0]             oALUSrcB,
    output logic                   oMemRead,
    output logic                   oMemWrite,
    output logic                   oMemtoReg,
    output logic                   oIoD,
    output logic                   oIRWrite,
    output logic                   oPCWrite,
    output logic                   oPCWriteCond,
    output logic [1:0]             oALUOp,
    output logic                   oPCSource,
    output logic [3:0]             oState,
    output logic                   oIllegal,
    output logic [COUNT_WIDTH-1:0] oCycleCount,
    output logic [COUNT_WIDTH-1:0] oInstrCount
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_ILLEGAL  = 4'd10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [3:0]             r_state;
    logic [3:0]             w_next;
    logic [COUNT_WIDTH-1:0] r_cycle;
    logic [COUNT_WIDTH-1:0] r_instr;
    logic [6:0]             w_opcode;
    logic                   w_unused_inst;
    logic                   w_retire;

    // funct3/funct7/register fields are not decoded by this unit
    assign w_opcode      = iInst[6:0];
    assign w_unused_inst = ^iInst[31:7];

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_BEQ:            w_next = S_BRANCH;
                    default:           w_next = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXEC_R:   w_next = S_ALUWB;
            S_EXEC_I:   w_next = S_ALUWB;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    // Reset overrides the FETCH decode so no strobe is seen while reset is high
    always_comb begin
        oRegWrite    = 1'b0;
        oALUSrcA     = 1'b0;
        oALUSrcB     = 2'b00;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oMemtoReg    = 1'b0;
        oIoD         = 1'b0;
        oIRWrite     = 1'b0;
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oALUOp       = 2'b00;
        oPCSource    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    oMemRead = 1'b1;
                    oIRWrite = 1'b1;
                    oALUSrcB = 2'b01;
                    oPCWrite = 1'b1;
                end
                S_DECODE: oALUSrcB = 2'b10;
                S_MEMADR: begin
                    oALUSrcA = 1'b1;
                    oALUSrcB = 2'b10;
                end
                S_MEMREAD: begin
                    oMemRead = 1'b1;
                    oIoD     = 1'b1;
                end
                S_MEMWB: begin
                    oRegWrite = 1'b1;
                    oMemtoReg = 1'b1;
                end
                S_MEMWRITE: begin
                    oMemWrite = 1'b1;
                    oIoD      = 1'b1;
                end
                S_EXEC_R: begin
                    oALUSrcA = 1'b1;
                    oALUOp   = 2'b10;
                end
                S_EXEC_I: begin
                    oALUSrcA = 1'b1;
                    oALUSrcB = 2'b10;
                    oALUOp   = 2'b11;
                end
                S_ALUWB: oRegWrite = 1'b1;
                S_BRANCH: begin
                    oALUSrcA     = 1'b1;
                    oALUOp       = 2'b01;
                    oPCWriteCond = 1'b1;
                    oPCSource    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                      (r_state == S_ALUWB) || (r_state == S_BRANCH);

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else begin
            if (r_state != S_ILLEGAL) begin
                r_cycle <= r_cycle + COUNT_WIDTH'(1);
            end
            if (w_retire) begin
                r_instr <= r_instr + COUNT_WIDTH'(1);
            end
        end
    end

    assign oState      = r_state;
    assign oIllegal    = (r_state == S_ILLEGAL);
    assign oCycleCount = r_cycle;
    assign oInstrCount = r_instr;

endmodule
